// File: rtl/capture_pkt_ctrl.sv
// Capture memory packetiser: reads packets of N words per channel from a
// capture memory (one-cycle read latency) and streams them with sop/eop
// framing, optional inter-word gaps and inter-packet idle periods.
module capture_pkt_ctrl #(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MEM_DEPTH = 13824,
    parameter int unsigned NUM_CH    = 2,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              capture_start,
    input  logic              capture_again,
    input  logic              loop_en,
    input  logic              self_test_mode,
    input  logic [1:0]        pkt_data_length,
    input  logic [7:0]        pkt_idle_length,
    input  logic [7:0]        pktctrl_gap,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [CH_W-1:0]   mem_rd_ch,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic [CH_W-1:0]   out_ch,
    output logic              busy,
    output logic              done
);

    // One extra bit so base + N + N never wraps in the end-of-window compare.
    localparam int unsigned AW1 = ADDR_W + 1;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StGap,
        StPktIdle,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [AW1-1:0]    base_q, base_d;
    logic [AW1-1:0]    word_q, word_d;
    logic [AW1-1:0]    len_q, len_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [7:0]        gap_q, gap_d;
    logic [7:0]        idle_q, idle_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              self_test_q, self_test_d;
    logic              loop_q, loop_d;
    logic [DATA_W-1:0] test_q, test_d;

    logic              valid_q, sop_q, eop_q;
    logic [CH_W-1:0]   och_q;
    logic [DATA_W-1:0] tdata_q;

    logic              rd_en;
    logic              accept;
    logic              last_word;
    logic              last_ch;
    logic [AW1-1:0]    next_base;
    logic              window_over;
    logic              finish;

    assign rd_en       = (state_q == StData);
    assign accept      = ((state_q == StIdle) && capture_start) ||
                         ((state_q == StDone) && (capture_start || capture_again));
    assign last_word   = (word_q == (len_q - AW1'(1)));
    assign last_ch     = (ch_q == CH_W'(NUM_CH - 1));
    assign next_base   = base_q + len_q;
    assign window_over = ((next_base + len_q) > AW1'(MEM_DEPTH));
    // Final read of the whole capture: every channel done on the last window.
    assign finish      = last_word && last_ch && window_over && !loop_q;

    // Next-state, address bookkeeping and config latching.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        word_d      = word_q;
        len_d       = len_q;
        ch_d        = ch_q;
        gap_d       = gap_q;
        idle_d      = idle_q;
        cnt_d       = cnt_q;
        self_test_d = self_test_q;
        loop_d      = loop_q;
        test_d      = test_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    len_d       = AW1'(216) << pkt_data_length;
                    gap_d       = pktctrl_gap;
                    idle_d      = pkt_idle_length;
                    self_test_d = self_test_mode;
                    loop_d      = loop_en;
                    base_d      = '0;
                    word_d      = '0;
                    ch_d        = '0;
                    test_d      = '0;
                    state_d     = StData;
                end
            end
            StData: begin
                test_d = test_q + DATA_W'(1);
                if (!last_word) begin
                    word_d = word_q + AW1'(1);
                    if (gap_q != 8'd0) begin
                        cnt_d   = gap_q - 8'd1;
                        state_d = StGap;
                    end
                end else begin
                    word_d = '0;
                    if (!last_ch) begin
                        ch_d = ch_q + CH_W'(1);
                    end else begin
                        ch_d   = '0;
                        base_d = window_over ? '0 : next_base;
                    end
                    if (finish) begin
                        state_d = StDone;
                    end else if (idle_q != 8'd0) begin
                        cnt_d   = idle_q - 8'd1;
                        state_d = StPktIdle;
                    end
                end
            end
            StGap, StPktIdle: begin
                if (cnt_q == 8'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state and latched configuration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            base_q      <= '0;
            word_q      <= '0;
            len_q       <= '0;
            ch_q        <= '0;
            gap_q       <= '0;
            idle_q      <= '0;
            cnt_q       <= '0;
            self_test_q <= 1'b0;
            loop_q      <= 1'b0;
            test_q      <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            word_q      <= word_d;
            len_q       <= len_d;
            ch_q        <= ch_d;
            gap_q       <= gap_d;
            idle_q      <= idle_d;
            cnt_q       <= cnt_d;
            self_test_q <= self_test_d;
            loop_q      <= loop_d;
            test_q      <= test_d;
        end
    end

    // Output framing, delayed one cycle to line up with the memory read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            och_q   <= '0;
            tdata_q <= '0;
        end else begin
            valid_q <= rd_en;
            sop_q   <= rd_en && (word_q == '0);
            eop_q   <= rd_en && last_word;
            och_q   <= rd_en ? ch_q : '0;
            tdata_q <= test_q;
        end
    end

    assign mem_rd_en   = rd_en;
    assign mem_rd_addr = rd_en ? ADDR_W'(base_q + word_q) : '0;
    assign mem_rd_ch   = rd_en ? ch_q : '0;

    // Memory data arrives combinationally in the valid cycle; gate to zero otherwise.
    assign out_data  = valid_q ? (self_test_q ? tdata_q : mem_rd_data) : '0;
    assign out_valid = valid_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign out_ch    = och_q;
    assign busy      = (state_q == StData) || (state_q == StGap) || (state_q == StPktIdle);
    assign done      = (state_q == StDone);

endmodule
